// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load/RAW stall and branch flush control beside a MEM/WB-only forwarding path
// Optional HAZARD_PERF_CNT_EN adds stall_cycles/flush_count performance counters.
module hazard_stall_unit #(
  parameter int REG_AW    = 5,
  parameter int STALL_EX  = 2,
  parameter int STALL_MEM = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] IF_ID_Rs1,
  input  logic [REG_AW-1:0] IF_ID_Rs2,
  input  logic              IF_ID_UsesRs1,
  input  logic              IF_ID_UsesRs2,
  input  logic [REG_AW-1:0] ID_EX_Rd,
  input  logic              ID_EX_RegWrite,
  input  logic [REG_AW-1:0] EX_MEM_Rd,
  input  logic              EX_MEM_RegWrite,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              IF_ID_write,
  output logic              ID_EX_bubble,
  output logic              IF_ID_flush,
  output logic              ID_EX_flush,
  output logic              stall_active
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
`endif
);

  localparam int CW = (STALL_EX > 0) ? $clog2(STALL_EX + 1) : 1;
  localparam logic [CW-1:0] NEED_EX  = CW'(STALL_EX);
  localparam logic [CW-1:0] NEED_MEM = CW'(STALL_MEM);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    STALLING = 1'b1
  } state_t;

  state_t          state, stateNext;
  logic [CW-1:0]   cnt, cntNext;
  logic [CW-1:0]   need;
  logic            matchEx, matchMem;
  logic            stall;

  // x0 is hardwired zero, so a write to it is never a real producer.
  always_comb begin
    matchEx  = ID_EX_RegWrite && (ID_EX_Rd != '0) &&
               ((IF_ID_UsesRs1 && (IF_ID_Rs1 == ID_EX_Rd)) ||
                (IF_ID_UsesRs2 && (IF_ID_Rs2 == ID_EX_Rd)));
    matchMem = EX_MEM_RegWrite && (EX_MEM_Rd != '0) &&
               ((IF_ID_UsesRs1 && (IF_ID_Rs1 == EX_MEM_Rd)) ||
                (IF_ID_UsesRs2 && (IF_ID_Rs2 == EX_MEM_Rd)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    stall     = 1'b0;
    need      = matchEx ? NEED_EX : (matchMem ? NEED_MEM : '0);
    case (state)
      IDLE: begin
        if (need != '0) begin
          stall     = 1'b1;
          cntNext   = need - CW'(1);
          stateNext = (need == CW'(1)) ? IDLE : STALLING;
        end
      end
      STALLING: begin
        // The bubble already in flight makes any new match moot.
        stall     = 1'b1;
        cntNext   = cnt - CW'(1);
        stateNext = (cnt == CW'(1)) ? IDLE : STALLING;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
    // A taken branch kills the consumer, so any pending stall is dropped.
    if (branch_taken) begin
      stall     = 1'b0;
      cntNext   = '0;
      stateNext = IDLE;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_bubble = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    if (!rst_n) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
    end else if (branch_taken) begin
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
    end else if (stall) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end
  end

  assign stall_active = (cnt != '0) && rst_n;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (branch_taken) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - randomized self-checking bench for hazard_stall_unit
// Reference model tracks the stall window as an end-cycle number; HAZARD_PERF_CNT_EN also checks the counters.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd, EX_MEM_Rd;
  logic       IF_ID_UsesRs1, IF_ID_UsesRs2, ID_EX_RegWrite, EX_MEM_RegWrite, branch_taken;
  logic       pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ID_EX_flush, stall_active;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int stallEnd = 0;
  int expStallCycles = 0;
  int expFlushCount = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.REG_AW(5), .STALL_EX(2), .STALL_MEM(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2),
    .IF_ID_UsesRs1(IF_ID_UsesRs1), .IF_ID_UsesRs2(IF_ID_UsesRs2),
    .ID_EX_Rd(ID_EX_Rd), .ID_EX_RegWrite(ID_EX_RegWrite),
    .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .branch_taken(branch_taken),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .ID_EX_bubble(ID_EX_bubble),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .stall_active(stall_active)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, observed, expected);
    end
  endtask

  // One clock: drive, check at the falling edge against the model, then advance the model.
  task automatic step(input logic rstn, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] exRd, input logic exW,
                      input logic [4:0] memRd, input logic memW, input logic br);
    logic [5:0] expOuts;
    logic       inStall, hitEx, hitMem, expStall;
    int         penalty;
    rst_n = rstn; IF_ID_Rs1 = rs1; IF_ID_UsesRs1 = u1; IF_ID_Rs2 = rs2; IF_ID_UsesRs2 = u2;
    ID_EX_Rd = exRd; ID_EX_RegWrite = exW; EX_MEM_Rd = memRd; EX_MEM_RegWrite = memW;
    branch_taken = br;
    @(negedge clk);
    inStall  = (cyc < stallEnd);
    hitEx    = exW && exRd != 0 && ((u1 && rs1 == exRd) || (u2 && rs2 == exRd));
    hitMem   = memW && memRd != 0 && ((u1 && rs1 == memRd) || (u2 && rs2 == memRd));
    penalty  = hitEx ? 2 : (hitMem ? 1 : 0);
    expStall = 1'b0;
    if (!rstn) begin
      expOuts  = 6'b00_1_11_0;
      stallEnd = 0;
      expStallCycles = 0;
      expFlushCount  = 0;
    end else if (br) begin
      expOuts  = {5'b11_0_11, inStall};
      stallEnd = 0;
      expFlushCount++;
    end else begin
      expStall = inStall || (penalty != 0);
      if (!inStall && penalty != 0) stallEnd = cyc + penalty;
      expOuts  = expStall ? {5'b00_1_00, inStall} : {5'b11_0_00, inStall};
      if (expStall) expStallCycles++;
    end
    checkEq("outs", {26'd0, pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ID_EX_flush, stall_active},
            {26'd0, expOuts});
    @(posedge clk);
    #1;
    cyc++;
`ifdef HAZARD_PERF_CNT_EN
    checkEq("stall_cycles", stall_cycles, expStallCycles);
    checkEq("flush_count", flush_count, expFlushCount);
`endif
  endtask

  function automatic logic [4:0] pickReg();
    return ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
  endfunction

  initial begin
    rst_n = 1'b0; IF_ID_Rs1 = '0; IF_ID_Rs2 = '0; IF_ID_UsesRs1 = 1'b0; IF_ID_UsesRs2 = 1'b0;
    ID_EX_Rd = '0; ID_EX_RegWrite = 1'b0; EX_MEM_Rd = '0; EX_MEM_RegWrite = 1'b0; branch_taken = 1'b0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 5, 1, 0, 0, 5, 1, 0, 0, 0);
    // EX-distance hazard: two stall cycles then release.
    step(1, 5, 1, 0, 0, 5, 1, 0, 0, 0);
    step(1, 5, 1, 0, 0, 5, 1, 0, 0, 0);
    step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    // MEM-distance hazard on Rs2: one stall cycle.
    step(1, 0, 0, 7, 1, 0, 0, 7, 1, 0);
    step(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
    // x0 and unused sources never stall.
    step(1, 0, 1, 0, 1, 0, 1, 0, 1, 0);
    step(1, 5, 0, 0, 0, 5, 1, 0, 0, 0);
    // Second EX hazard, then branch cancels the pending cycle.
    step(1, 5, 1, 0, 0, 5, 1, 0, 0, 0);
    step(1, 5, 1, 0, 0, 5, 1, 0, 0, 1);
    step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    // Third EX hazard then a full second stall cycle, branch with a fresh match.
    step(1, 3, 1, 0, 0, 3, 1, 0, 0, 0);
    step(1, 3, 1, 0, 0, 3, 1, 0, 0, 0);
    step(1, 2, 1, 0, 0, 2, 1, 0, 0, 1);
    step(1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5, 1, 0, 0, 5, 1, 0, 0, 0);
    step(1, 5, 1, 0, 0, 5, 1, 0, 0, 0);
    step(1, 6, 1, 0, 0, 6, 1, 0, 0, 0);
    step(1, 6, 1, 0, 0, 6, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkEq("perf_stall_total", stall_cycles, 32'd4);
    checkEq("perf_flush_total", flush_count, 32'd1);
`endif
    // Reset in the middle of a stall leaves nothing behind.
    step(1, 4, 1, 0, 0, 4, 1, 0, 0, 0);
    step(0, 4, 1, 0, 0, 4, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) != 0),
           pickReg(), 1'($urandom_range(0, 1)), pickReg(), 1'($urandom_range(0, 1)),
           pickReg(), 1'($urandom_range(0, 3) != 0), pickReg(), 1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
